// File: rtl/fme_pkg.sv
// -----------------------------------------------------------------------------
// fme_pkg
//   Shared definitions for the fractional motion estimation (FME) interpolation
//   datapath:
//     - pixel width (8) and filter intermediate width (15, signed)
//     - H.264 6-tap luma half-pel coefficients (1, -5, 20)
//     - rounding offset (16) and normalising shift (5)
//     - hsum_t: signed type for the raw 6-tap sum
//     - hpf_state_t: row-filter column state (FILL / RUN)
//     - round_clip(): (s + 16) >>> 5, saturated to 0..255
// -----------------------------------------------------------------------------
package fme_pkg;

  localparam int PIX_W = 8;
  localparam int SUM_W = 15;

  // Raw 6-tap sum. Its range is -2550..10710, which fits in 15 signed bits.
  typedef logic signed [SUM_W-1:0] hsum_t;

  // Coefficients for the outer (A,F), next (B,E) and centre (C,D) tap pairs.
  localparam hsum_t TAP_AF = 15'sd1;
  localparam hsum_t TAP_BE = -15'sd5;
  localparam hsum_t TAP_CD = 15'sd20;

  localparam hsum_t RND_OFS   = 15'sd16;
  localparam int    RND_SHIFT = 5;

  typedef enum logic {
    ST_FILL = 1'b0,  // window still being primed for this row
    ST_RUN  = 1'b1   // every accepted pixel completes a window
  } hpf_state_t;

  // Round to nearest and saturate to an unsigned pixel. The arithmetic shift
  // keeps negative sums negative, so the sign bit alone selects the low clip.
  function automatic logic [PIX_W-1:0] round_clip(input hsum_t s);
    hsum_t r;
    r = (s + RND_OFS) >>> RND_SHIFT;
    if (r[SUM_W-1]) begin
      round_clip = '0;
    end else if (r > 15'sd255) begin
      round_clip = '1;
    end else begin
      round_clip = r[PIX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/hpf_tap6.sv
// -----------------------------------------------------------------------------
// hpf_tap6
//   Combinational H.264 6-tap half-pel kernel:
//     s = (a + f) - 5*(b + e) + 20*(c + d)
//   The result is the unrounded, unclipped signed sum. Shared by the
//   horizontal row filter and the vertical filter.
//
// Ports:
//   a..f  in  8   unsigned integer-pel taps, a is the oldest / leftmost
//   s     out 15  signed raw filter sum (hsum_t)
// -----------------------------------------------------------------------------
module hpf_tap6
  import fme_pkg::*;
(
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  input  logic [PIX_W-1:0] c,
  input  logic [PIX_W-1:0] d,
  input  logic [PIX_W-1:0] e,
  input  logic [PIX_W-1:0] f,
  output hsum_t            s
);

  hsum_t ea, eb, ec, ed, ee, ef;

  // Zero-extend the unsigned taps into the signed domain before any subtraction.
  assign ea = hsum_t'({{(SUM_W-PIX_W){1'b0}}, a});
  assign eb = hsum_t'({{(SUM_W-PIX_W){1'b0}}, b});
  assign ec = hsum_t'({{(SUM_W-PIX_W){1'b0}}, c});
  assign ed = hsum_t'({{(SUM_W-PIX_W){1'b0}}, d});
  assign ee = hsum_t'({{(SUM_W-PIX_W){1'b0}}, e});
  assign ef = hsum_t'({{(SUM_W-PIX_W){1'b0}}, f});

  // Each pair sum is at most 510, so every product stays inside 15 bits.
  assign s = (TAP_AF * (ea + ef)) + (TAP_BE * (eb + ee)) + (TAP_CD * (ec + ed));

endmodule

// File: rtl/half_pel_row_filter.sv
// -----------------------------------------------------------------------------
// half_pel_row_filter
//   Streaming horizontal H.264 luma half-pel interpolator. Takes one
//   integer-pel row of ROW_LEN pixels. Once the 6-tap window A..F is full,
//   each accepted pixel launches one half-pel sample. That sample lies between
//   taps C and D and is emitted with C and D, so the quarter-pel averager can
//   use all three.
//
//   Pipeline: window (edge k) -> raw sum (edge k+1) -> rounded/clipped output
//   (edge k+2). Throughput is one sample per clock, and each row yields
//   ROW_LEN-5 samples.
//
// Handshake:
//   A beat transfers on a rising edge where valid && ready. The output
//   register is stalled whenever it holds data that is not being taken, and
//   that stall (en) freezes the whole pipeline, including the input side.
//   While out_valid=1 and out_ready=0, out_* hold steady.
//
// Optional build macro:
//   HPF_RAW_OUT_EN - adds out_hraw, the raw signed 6-tap sum aligned with
//                    out_hpel. When undefined, stage 2 keeps only the
//                    clipped byte.
//
// Ports:
//   clk         in   1   rising-edge clock
//   rst_n       in   1   asynchronous active-low reset
//   flush       in   1   synchronous abort of the current row and pipeline
//   in_valid    in   1   input pixel valid
//   in_ready    out  1   pixel can be accepted this cycle
//   in_pix      in   8   integer-pel luma sample
//   out_valid   out  1   output sample valid
//   out_ready   in   1   downstream accepts the output
//   out_hpel    out  8   clipped half-pel between taps C and D
//   out_fpel_l  out  8   full-pel tap C
//   out_fpel_r  out  8   full-pel tap D
//   out_last    out  1   last half-pel of the row
//   out_hraw    out  15  raw signed sum (HPF_RAW_OUT_EN only)
// -----------------------------------------------------------------------------
module half_pel_row_filter
  import fme_pkg::*;
#(
  parameter int ROW_LEN = 22,
  parameter int COL_W   = $clog2(ROW_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_hpel,
  output logic [PIX_W-1:0] out_fpel_l,
  output logic [PIX_W-1:0] out_fpel_r,
  output logic             out_last
`ifdef HPF_RAW_OUT_EN
  ,
  output hsum_t            out_hraw
`endif
);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(ROW_LEN - 1);
  // The window is complete once five pixels are already in it.
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(5);

  // ---------------------------------------------------------------------------
  // Handshake and global stall
  // ---------------------------------------------------------------------------
  logic en;
  logic accept;

  assign en       = !out_valid || out_ready;
  assign in_ready = en && !flush;
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Column FSM: FILL primes the window, RUN launches one output per pixel
  // ---------------------------------------------------------------------------
  hpf_state_t       state, state_nxt;
  logic [COL_W-1:0] col, col_nxt;
  logic             launch;
  logic             row_end;

  assign row_end = (col == COL_LAST);
  assign launch  = accept && (state == ST_RUN);

  always_comb begin
    col_nxt   = col;
    state_nxt = state;
    if (flush) begin
      col_nxt   = '0;
      state_nxt = ST_FILL;
    end else if (accept) begin
      if (row_end) begin
        col_nxt   = '0;
        state_nxt = ST_FILL;
      end else begin
        col_nxt = col + 1'b1;
        if (col_nxt == COL_FIRST) begin
          state_nxt = ST_RUN;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col   <= '0;
      state <= ST_FILL;
    end else begin
      col   <= col_nxt;
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Tap window: A is oldest, new pixels enter at F. It is not cleared between
  // rows or on flush, because the next FILL phase overwrites all six taps.
  // ---------------------------------------------------------------------------
  logic [PIX_W-1:0] wa, wb, wc, wd, we, wf;
  logic             w_valid;  // window holds a completed, not-yet-summed set
  logic             w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wa <= '0;
      wb <= '0;
      wc <= '0;
      wd <= '0;
      we <= '0;
      wf <= '0;
    end else if (accept) begin
      wa <= wb;
      wb <= wc;
      wc <= wd;
      wd <= we;
      we <= wf;
      wf <= in_pix;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_valid <= 1'b0;
      w_last  <= 1'b0;
    end else if (flush) begin
      w_valid <= 1'b0;
      w_last  <= 1'b0;
    end else if (en) begin
      // Without a launch this clears the flag, so no bubble is ever marked valid.
      w_valid <= launch;
      w_last  <= launch && row_end;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: raw 6-tap sum plus the C/D taps that go with it
  // ---------------------------------------------------------------------------
  hsum_t            sum;
  logic             s1_valid;
  logic             s1_last;
  hsum_t            s1_sum;
  logic [PIX_W-1:0] s1_c, s1_d;

  hpf_tap6 u_tap6 (
    .a (wa),
    .b (wb),
    .c (wc),
    .d (wd),
    .e (we),
    .f (wf),
    .s (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_sum   <= '0;
      s1_c     <= '0;
      s1_d     <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else if (en) begin
      s1_valid <= w_valid;
      s1_last  <= w_last;
      // The window can shift on this same edge. The sum uses the pre-edge taps.
      if (w_valid) begin
        s1_sum <= sum;
        s1_c   <= wc;
        s1_d   <= wd;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: rounded and clipped output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_hpel   <= '0;
      out_fpel_l <= '0;
      out_fpel_r <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (en) begin
      out_valid <= s1_valid;
      out_last  <= s1_valid && s1_last;
      if (s1_valid) begin
        out_hpel   <= round_clip(s1_sum);
        out_fpel_l <= s1_c;
        out_fpel_r <= s1_d;
      end
    end
  end

`ifdef HPF_RAW_OUT_EN
  // Raw sum for the vertical pass, which forms the centre (j) position from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_hraw <= '0;
    end else if (!flush && en && s1_valid) begin
      out_hraw <= s1_sum;
    end
  end
`endif

endmodule

// File: tb/tb_half_pel_row_filter.sv
module tb_half_pel_row_filter;

  localparam int ROW_LEN = 22;
  localparam int NOUT    = ROW_LEN - 5;
  localparam int W       = 25;  // {last, fpel_l, fpel_r, hpel}

  typedef logic [7:0] row_t [ROW_LEN];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_pix = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_hpel;
  logic [7:0] out_fpel_l;
  logic [7:0] out_fpel_r;
  logic       out_last;
`ifdef HPF_RAW_OUT_EN
  logic signed [14:0] out_hraw;
`endif

  half_pel_row_filter #(.ROW_LEN(ROW_LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pix     (in_pix),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_hpel   (out_hpel),
    .out_fpel_l (out_fpel_l),
    .out_fpel_r (out_fpel_r),
    .out_last   (out_last)
`ifdef HPF_RAW_OUT_EN
    ,
    .out_hraw   (out_hraw)
`endif
  );

  // ---------------------------------------------------------------------------
  // Clock / watchdog
  // ---------------------------------------------------------------------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;
  int out_count = 0;
  int last_count = 0;
  logic [W-1:0] exp_q[$];
`ifdef HPF_RAW_OUT_EN
  int raw_q[$];
`endif
  int row_buf[ROW_LEN];
  int m_col = 0;
  bit rand_rdy = 0;

  function automatic int model_sum(int a, int b, int c, int d, int e, int f);
    return (a + f) - 5 * (b + e) + 20 * (c + d);
  endfunction

  function automatic int model_hpel(int s);
    int r;
    if (s + 16 < 0) return 0;
    r = (s + 16) / 32;
    if (r > 255) return 255;
    return r;
  endfunction

  task automatic model_clear();
    exp_q.delete();
`ifdef HPF_RAW_OUT_EN
    raw_q.delete();
`endif
    m_col = 0;
  endtask

  // Inputs and outputs are sampled mid-cycle; a beat seen here transfers on
  // the following rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        logic [W-1:0] exp_v;
        out_count++;
        if (out_last) last_count++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got last=%0d l=%0d r=%0d hpel=%0d, expected none",
                   out_last, out_fpel_l, out_fpel_r, out_hpel);
        end else begin
          exp_v = exp_q.pop_front();
          if ({out_last, out_fpel_l, out_fpel_r, out_hpel} !== exp_v) begin
            errors++;
            $display("FAIL output_data: got last=%0d l=%0d r=%0d hpel=%0d, expected last=%0d l=%0d r=%0d hpel=%0d",
                     out_last, out_fpel_l, out_fpel_r, out_hpel,
                     exp_v[24], exp_v[23:16], exp_v[15:8], exp_v[7:0]);
          end
        end
`ifdef HPF_RAW_OUT_EN
        if (raw_q.size() != 0) begin
          int exp_raw;
          exp_raw = raw_q.pop_front();
          checks++;
          if (out_hraw !== 15'(exp_raw)) begin
            errors++;
            $display("FAIL output_raw: got %0d expected %0d", out_hraw, exp_raw);
          end
        end
`endif
      end
      if (in_valid && in_ready) begin
        row_buf[m_col] = int'(in_pix);
        if (m_col >= 5) begin
          int s;
          s = model_sum(row_buf[m_col-5], row_buf[m_col-4], row_buf[m_col-3],
                        row_buf[m_col-2], row_buf[m_col-1], row_buf[m_col]);
          exp_q.push_back({(m_col == ROW_LEN - 1), 8'(row_buf[m_col-3]),
                           8'(row_buf[m_col-2]), 8'(model_hpel(s))});
`ifdef HPF_RAW_OUT_EN
          raw_q.push_back(s);
`endif
        end
        m_col = (m_col == ROW_LEN - 1) ? 0 : m_col + 1;
      end
    end
  end

  // Random output backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(3, 0) != 0);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (entered and left at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic drive_pix(input logic [7:0] p, input int gap);
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_pix   = p;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL input_timeout: in_ready=0 for 200 cycles, expected 1");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_row(input row_t px, input int max_gap);
    for (int i = 0; i < ROW_LEN; i++) begin
      drive_pix(px[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
    end
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 400; t++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d outputs still expected, required 0", exp_q.size());
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    #3;
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    if (out_hpel !== 8'd0) begin errors++; $display("FAIL reset_out_hpel: got %0d expected 0", out_hpel); end
    if (out_fpel_l !== 8'd0) begin errors++; $display("FAIL reset_out_fpel_l: got %0d expected 0", out_fpel_l); end
    if (out_fpel_r !== 8'd0) begin errors++; $display("FAIL reset_out_fpel_r: got %0d expected 0", out_fpel_r); end
`ifdef HPF_RAW_OUT_EN
    checks++;
    if (out_hraw !== 15'sd0) begin errors++; $display("FAIL reset_out_hraw: got %0d expected 0", out_hraw); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_const_row();
    int c0, l0;
    c0 = out_count;
    l0 = last_count;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) drive_pix(8'd100, 0);
    // Sixth pixel just taken: out_valid must rise two clocks later.
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_k0: out_valid got %b expected 0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_k1: out_valid got %b expected 0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_k2: out_valid got %b expected 1", out_valid); end
    checks++;
    if (out_hpel !== 8'd100) begin errors++; $display("FAIL const_first_hpel: got %0d expected 100", out_hpel); end
    @(posedge clk);
    #1;
    for (int i = 6; i < ROW_LEN; i++) drive_pix(8'd100, 0);
    wait_drain();
    checks += 2;
    if (out_count - c0 != NOUT) begin errors++; $display("FAIL const_count: got %0d expected %0d", out_count - c0, NOUT); end
    if (last_count - l0 != 1) begin errors++; $display("FAIL const_last_count: got %0d expected 1", last_count - l0); end
  endtask

  task automatic test_ramp();
    row_t px;
    int c0;
    c0 = out_count;
    for (int i = 0; i < ROW_LEN; i++) px[i] = 8'(10 * i);
    fork
      send_row(px, 0);
      begin
        for (int t = 0; t < 60; t++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        checks += 3;
        if (out_hpel !== 8'd25) begin errors++; $display("FAIL ramp_first_hpel: got %0d expected 25", out_hpel); end
        if (out_fpel_l !== 8'd20) begin errors++; $display("FAIL ramp_first_l: got %0d expected 20", out_fpel_l); end
        if (out_fpel_r !== 8'd30) begin errors++; $display("FAIL ramp_first_r: got %0d expected 30", out_fpel_r); end
      end
    join
    @(posedge clk);
    #1;
    wait_drain();
    checks++;
    if (out_count - c0 != NOUT) begin errors++; $display("FAIL ramp_count: got %0d expected %0d", out_count - c0, NOUT); end
  endtask

  task automatic test_clip();
    row_t px;
    logic [7:0] hi_lo [12];
    int c0;
    c0 = out_count;
    hi_lo = '{8'd0, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0,
              8'd255, 8'd255, 8'd0, 8'd0, 8'd255, 8'd255};
    for (int i = 0; i < ROW_LEN; i++) px[i] = (i < 12) ? hi_lo[i] : 8'($urandom_range(255, 0));
    send_row(px, 0);
    wait_drain();
    checks++;
    if (out_count - c0 != NOUT) begin errors++; $display("FAIL clip_count: got %0d expected %0d", out_count - c0, NOUT); end
  endtask

  task automatic test_stall();
    row_t px;
    int c0;
    c0 = out_count;
    for (int i = 0; i < ROW_LEN; i++) px[i] = 8'($urandom_range(255, 0));
    fork
      send_row(px, 0);
      begin
        logic [25:0] snap;
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        snap = {out_valid, out_hpel, out_fpel_l, out_fpel_r, out_last};
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", out_valid); end
        for (int c = 0; c < 3; c++) begin
          if (c > 0) @(negedge clk);
          checks += 2;
          if ({out_valid, out_hpel, out_fpel_l, out_fpel_r, out_last} !== snap) begin
            errors++;
            $display("FAIL stall_hold: got %h expected %h", {out_valid, out_hpel, out_fpel_l, out_fpel_r, out_last}, snap);
          end
          if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    checks++;
    if (out_count - c0 != NOUT) begin errors++; $display("FAIL stall_count: got %0d expected %0d", out_count - c0, NOUT); end
  endtask

  task automatic test_flush();
    row_t px;
    int c0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) drive_pix(8'($urandom_range(255, 0)), 0);
    // Flush with a pixel offered in the same cycle: that pixel must be dropped.
    flush = 1'b1;
    in_valid = 1'b1;
    in_pix = 8'd77;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    model_clear();
    c0 = out_count;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid_%0d: got %b expected 0", c, out_valid); end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < ROW_LEN; i++) px[i] = 8'($urandom_range(255, 0));
    send_row(px, 0);
    wait_drain();
    checks++;
    if (out_count - c0 != NOUT) begin errors++; $display("FAIL flush_count: got %0d expected %0d", out_count - c0, NOUT); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) drive_pix(8'($urandom_range(255, 0)), 0);
    #2;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b expected 1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid: got %b expected 0", out_valid); end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_const_row();
  endtask

  task automatic test_random();
    row_t px;
    int c0, l0;
    c0 = out_count;
    l0 = last_count;
    rand_rdy = 1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < ROW_LEN; i++) px[i] = 8'($urandom_range(255, 0));
      send_row(px, 2);
    end
    wait_drain();
    rand_rdy = 0;
    out_ready = 1'b1;
    checks += 2;
    if (out_count - c0 != 4 * NOUT) begin errors++; $display("FAIL random_count: got %0d expected %0d", out_count - c0, 4 * NOUT); end
    if (last_count - l0 != 4) begin errors++; $display("FAIL random_last_count: got %0d expected 4", last_count - l0); end
  endtask

  initial begin
    test_reset();
    test_const_row();
    test_ramp();
    test_clip();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/half_pel_row_filter.md
Name: half_pel_row_filter

Overview:
Streaming horizontal H.264 luma half-pel interpolator for the FME datapath. Takes one integer-pel reference row per pass, applies the 6-tap filter (1,-5,20,20,-5,1), rounds and clips the result, and emits each half-pel sample together with its two neighbouring full-pel samples. The quarter-pel averaging stage directly downstream consumes these three samples.

Parameters:
ROW_LEN, 22, integer pixels per input row; must be >= 6. The default is a 16-wide block plus 6 taps of margin.
COL_W, $clog2(ROW_LEN), width of the column counter. Derived; do not override.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous abort of the current row and pipeline contents
in_valid  in  1  input pixel valid
in_ready  out  1  block can accept a pixel this cycle
in_pix  in  8  integer-pel luma sample, unsigned
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts the output
out_hpel  out  8  clipped half-pel sample between window taps C and D
out_fpel_l  out  8  full-pel sample C (left of the half-pel)
out_fpel_r  out  8  full-pel sample D (right of the half-pel)
out_last  out  1  marks the last half-pel of a row

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Column counter = 0; state = FILL.
  - Window and pipeline registers = 0.
  - out_valid = 0; out_last = 0; out_hpel, out_fpel_l and out_fpel_r = 0.
  - in_ready goes to 1 in the first cycle after reset deasserts.
- Transfer rule: a transfer occurs when valid && ready on a rising edge.
- Global stall:
  - en = !out_valid || out_ready.
  - in_ready = en && !flush.
  - When en is 0, every pipeline register holds its value.
  - Output data is stable while out_valid=1 and out_ready=0.
- Window: six 8-bit taps A..F. An accepted pixel shifts in at F; A is the oldest.
- States, driven by column counter col:
  - FILL (col 0..4): accepted pixels only fill the window; no output is produced.
  - RUN (col 5..ROW_LEN-1): each accepted pixel completes a window and launches one output.
  - Accepting the pixel at col ROW_LEN-1 sets col to 0 and returns to FILL.
  - The window is not cleared between rows; FILL overwrites it.
- Pipeline, measured from edge k where the completing pixel is accepted (no stall):
  - Edge k+1: stage 1 registers the sum.
  - Edge k+2: stage 2 registers the clipped result.
  - out_valid is therefore high after edge k+2, giving a latency of 2 clocks.
  - Full throughput is 1 output per clock.
- Outputs per row: ROW_LEN-5, so 17 at the default.
- Arithmetic:
  - s = (A+F) - 5*(B+E) + 20*(C+D), computed in a 15-bit signed intermediate. The range is -2550..10710.
  - out_hpel = clip((s+16)>>>5, 0, 255).
- Full-pel outputs: out_fpel_l and out_fpel_r carry C and D from the same window, aligned with out_hpel.
- out_last is 1 exactly on the output whose window completed at col ROW_LEN-1.
- Boundary conditions:
  - in_valid is ignored while in_ready=0.
  - When in_valid=0, no bubble propagates as valid data; stage valids track the launch.
  - flush=1 on an edge: col=0, state=FILL, stage valids and out_valid cleared. This holds even if out_ready=0, and in the same cycle any in_valid pixel is dropped.
  - Async reset mid-row gives the same clearing effect as flush.

Optional Feature:
Macro HPF_RAW_OUT_EN.
- When defined: adds output port out_hraw (15-bit signed). It carries the unrounded, unclipped s, aligned with out_hpel and qualified by out_valid. The vertical pass uses it to form the centre (j) half-pel position. Reset value is 0.
- When undefined: the port is absent. Stage 2 keeps only the clipped byte.

Decomposition:
- Shared package fme_pkg holds:
  - tap constants (1, -5, 20);
  - rounding offset 16 and shift 5;
  - the pixel width 8 and intermediate width 15;
  - a typedef for the signed intermediate.
- One sub-module is natural: hpf_tap6. It is combinational: six 8-bit taps in, 15-bit signed s out. It is reused later by the vertical filter.

Test Plan:
- Row of 22 pixels all equal to 100, out_ready=1 -> 17 outputs, all with out_hpel=100. out_last is set only on the 17th output, and out_valid is first set 2 clocks after the 6th pixel is accepted.
- Ramp in_pix=10*i for i=0..21 -> first out_hpel=25 with out_fpel_l=20 and out_fpel_r=30. Successive outputs are 35, 45, ... up to 185.
- Window 0,0,255,255,0,0 (s=10200) -> out_hpel=255. Window 255,255,0,0,255,255 (s=-2040) -> out_hpel=0. With HPF_RAW_OUT_EN defined, out_hraw shows 10200 and -2040.
- Hold out_ready=0 for 3 cycles mid-row -> out_* stay stable and in_ready=0. No sample is lost or duplicated; the row still yields 17 outputs in order.
- Assert flush after 10 pixels of a row, then send a full new row -> nothing from the aborted row appears. The new row yields 17 correct outputs.
- Pulse rst_n low mid-row -> out_valid drops immediately (asynchronously). The next full row behaves identically to the first test.
